// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and field constants for the picoMIPS fetch unit
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Loader / execution phases of the fetch unit
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Opcode field occupies the top OPC_W bits of the instruction word
    localparam int OPC_W  = 3;
    // Loader transfers one byte per handshake
    localparam int BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem
//  Purpose  : Program store, synchronous write port, asynchronous read port.
//             Contents are deliberately not reset so a program survives reset.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_mem #(
    parameter int IWIDTH = 16,
    parameter int PSIZE  = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PSIZE-1:0]  waddr,
    input  logic [IWIDTH-1:0] wdata,
    input  logic [PSIZE-1:0]  raddr,
    output logic [IWIDTH-1:0] rdata
);

    logic [IWIDTH-1:0] mem_q [2**PSIZE];

    // Write port: one word per cycle from the boot loader
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/prog_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : prog_fetch
//  Purpose  : Instruction supply for picoMIPS: byte-serial boot loader,
//             program memory, program counter and branch/halt handling.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_fetch
    import fetch_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int PSIZE  = 5,
    parameter int OFFW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              PCincr,
    input  logic              PCrelbranch,
    output logic [IWIDTH-1:0] instr,
    output logic [OPC_W-1:0]  opcode,
    output logic [PSIZE-1:0]  pc,
    output logic              exec_en,
    output logic              halted
);

    localparam int NBYTES = IWIDTH / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW     = (PSIZE > OFFW) ? PSIZE : OFFW;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NBYTES - 1);
    localparam logic [PSIZE-1:0] C_TOP_ADDR = '1;

    fetch_state_t      state_q, state_d;
    logic [PSIZE-1:0]  pc_q, pc_d;
    logic [PSIZE-1:0]  load_addr_q, load_addr_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IWIDTH-1:0] shift_q, shift_d;

    logic [IWIDTH-1:0] w_shift_next;
    logic [CNT_W-1:0]  w_pad_bytes;
    logic [IWIDTH-1:0] w_commit_word;
    logic              w_commit;
    logic [OFFW-1:0]   w_offset;

    // Incoming byte enters at the bottom; a short final word is left-justified
    // by shifting in as many zero bytes as are still missing.
    assign w_shift_next  = (shift_q << BYTE_W) | IWIDTH'(ld_data);
    assign w_pad_bytes   = C_LAST_CNT - byte_cnt_q;
    assign w_commit_word = w_shift_next << {w_pad_bytes, 3'b000};
    assign w_offset      = instr[OFFW-1:0];

    // Loader FSM, byte assembler and PC next-state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_addr_d = load_addr_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        w_commit    = 1'b0;
        case (state_q)
            LOAD: begin
                if (ld_valid) begin
                    if ((byte_cnt_q == C_LAST_CNT) || ld_last) begin
                        w_commit    = 1'b1;
                        load_addr_d = load_addr_q + 1'b1;
                        byte_cnt_d  = '0;
                        shift_d     = '0;
                        // Explicit end of program, or the last slot was just filled
                        if (ld_last || (load_addr_q == C_TOP_ADDR)) begin
                            state_d = RUN;
                            pc_d    = '0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = w_shift_next;
                    end
                end
            end
            RUN: begin
                if (PCrelbranch) begin
                    // Branch-to-self is the halt idiom: freeze instead of spinning
                    if (w_offset == '0) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + PSIZE'(SW'($signed(w_offset)));
                    end
                end else if (PCincr) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State registers with synchronous reset; program memory is not touched here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            pc_q        <= '0;
            load_addr_q <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            load_addr_q <= load_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
        end
    end

    // A word completing in the reset cycle belongs to the aborted load
    prog_mem #(
        .IWIDTH (IWIDTH),
        .PSIZE  (PSIZE)
    ) u_prog_mem (
        .clk   (clk),
        .we    (w_commit && !reset),
        .waddr (load_addr_q),
        .wdata (w_commit_word),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign opcode   = instr[IWIDTH-1 -: OPC_W];
    assign pc       = pc_q;
    assign ld_ready = (state_q == LOAD);
    assign exec_en  = (state_q == RUN);
    assign halted   = (state_q == HALT);

endmodule
`default_nettype wire
